spram_bank: RTL

SPRAM_BANK -- requirements
Module: spram_bank

---
 rtl/spram_pkg.sv | 22 ++
 rtl/spram_tile.sv | 40 ++++
 rtl/spram_bank.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared types and tile geometry for the SPRAM bank.
// One tile is a 16-bit x 16K single-port RAM with a nibble write mask.
package spram_pkg;

  typedef enum logic [1:0] {
    PWR_WAKE,
    PWR_ACTIVE,
    PWR_SLEEP
  } pwr_state_e;

  localparam int TILE_WIDTH = 16;
  localparam int TILE_DEPTH = 16384;
  localparam int TILE_AW    = 14;
  localparam int MAX_TILES  = 4;

  function automatic logic [3:0] be2mask(
    input logic [1:0] be
  );
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/spram_tile.sv
// One SB_SPRAM256KA-equivalent tile: synchronous read, nibble-masked
// write, POWEROFF active-low, no access while SLEEP or STANDBY.
module spram_tile
  import spram_pkg::*;
(
  input  logic                  clk,
  input  logic [TILE_AW-1:0]    addr,
  input  logic [TILE_WIDTH-1:0] wdata,
  input  logic [3:0]            mask,
  input  logic                  we,
  input  logic                  cs,
  input  logic                  sleep,
  input  logic                  standby,
  input  logic                  poweroff,
  output logic [TILE_WIDTH-1:0] rdata
);

  logic [TILE_WIDTH-1:0] mem [TILE_DEPTH];
  logic [TILE_WIDTH-1:0] bmask;
  logic                  en;

  assign en = cs & ~sleep & ~standby & poweroff;

  always_comb begin
    bmask = '0;
    for (int n = 0; n < 4; n++) begin
      bmask[n*4 +: 4] = {4{mask[n]}};
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
    end
    if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_bank.sv
// Banked SPRAM with a wake/active/sleep power FSM and one-cycle
// read latency; upper address bits select the bank.
module spram_bank
  import spram_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int BANKS       = 2,
  parameter  int WAKE_CYCLES = 4,
  localparam int DEPTH       = BANKS * TILE_DEPTH,
  localparam int ADDRW       = $clog2(DEPTH),
  localparam int BEW         = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [BEW-1:0]   req_be,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  input  logic             sleep_req,
  output logic             sleep_ack
);

  localparam int HALVES = WIDTH / TILE_WIDTH;
  localparam int BSW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int NSLOT  = 2 ** BSW;
  localparam logic [7:0] WC8 = 8'(WAKE_CYCLES);

  if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("spram_bank: WIDTH must be 16 or 32");
  end
  if (BANKS != 1 && BANKS != 2 && BANKS != 4) begin : g_bad_banks
    $error("spram_bank: BANKS must be 1, 2 or 4");
  end
  if (BANKS * HALVES > MAX_TILES) begin : g_too_many
    $error("spram_bank: BANKS*WIDTH/16 exceeds tile count");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("spram_bank: WAKE_CYCLES must be 1..255");
  end

  pwr_state_e     state;
  logic [7:0]     cnt;
  logic           accept;
  logic           rd_acc;
  logic           tile_sleep;
  logic [BSW-1:0] bank;
  logic [BSW-1:0] rsp_bank;
  logic [WIDTH-1:0] bank_rdata [NSLOT];

  if (BANKS > 1) begin : g_bsel
    assign bank = req_addr[ADDRW-1 -: BSW];
  end else begin : g_bsel1
    assign bank = '0;
  end

  assign req_ready  = (state == PWR_ACTIVE) & ~sleep_req;
  assign accept     = req_valid & req_ready;
  assign rd_acc     = accept & ~req_we;
  assign tile_sleep = (state == PWR_SLEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAKE;
      cnt       <= WC8;
      sleep_ack <= 1'b0;
    end else begin
      unique case (state)
        PWR_WAKE: begin
          if (cnt == 8'd1) begin
            state <= PWR_ACTIVE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PWR_ACTIVE: begin
          if (sleep_req) begin
            state     <= PWR_SLEEP;
            sleep_ack <= 1'b1;
          end
        end
        PWR_SLEEP: begin
          if (!sleep_req) begin
            state     <= PWR_WAKE;
            cnt       <= WC8;
            sleep_ack <= 1'b0;
          end
        end
        default: begin
          state     <= PWR_WAKE;
          cnt       <= WC8;
          sleep_ack <= 1'b0;
        end
      endcase
    end
  end

  // Bank is captured at accept so the mux follows the tile output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_bank  <= '0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_bank <= bank;
      end
    end
  end

  for (genvar b = 0; b < NSLOT; b++) begin : g_bank
    if (b < BANKS) begin : g_real
      for (genvar h = 0; h < HALVES; h++) begin : g_half
        spram_tile u_tile (
          .clk      (clk),
          .addr     (req_addr[TILE_AW-1:0]),
          .wdata    (req_wdata[h*TILE_WIDTH +: TILE_WIDTH]),
          .mask     (be2mask(req_be[h*2 +: 2])),
          .we       (req_we),
          .cs       (accept && (bank == BSW'(b))),
          .sleep    (tile_sleep),
          .standby  (1'b0),
          .poweroff (1'b1),
          .rdata    (bank_rdata[b][h*TILE_WIDTH +: TILE_WIDTH])
        );
      end
    end else begin : g_empty
      assign bank_rdata[b] = '0;
    end
  end

  assign rsp_rdata = bank_rdata[rsp_bank];

endmodule
